// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 16xW register file: in-order writeback (A) has priority,
// a multi-cycle unit (B) queues through a small FIFO with starvation protection.
module regfile_write_arbiter #(
    parameter int W          = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    input  logic [3:0]   a_addr,
    input  logic [W-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [3:0]   b_addr,
    input  logic [W-1:0] b_data,
    output logic         stall_a,
    input  logic [3:0]   rd_addr0,
    input  logic [3:0]   rd_addr1,
    output logic         pending0,
    output logic         pending1,
    output logic         wr_en,
    output logic [3:0]   wr_addr,
    output logic [W-1:0] wr_data,
    output logic         err_r15
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [3:0] PC_REG = 4'hF;

    logic [3:0]    fifo_addr [DEPTH];
    logic [W-1:0]  fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          sel_req;
    logic          sel_r15;
    logic          sel_wr;
    logic [3:0]    sel_addr;
    logic [W-1:0]  sel_data;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign b_ready    = ~fifo_full;
    assign push       = b_valid & ~fifo_full;
    // A always wins the port; the FIFO head only drains on cycles A is idle.
    assign pop        = ~a_valid & ~fifo_empty;
    assign stall_a    = (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        sel_req  = a_valid | ~fifo_empty;
        sel_addr = a_valid ? a_addr : fifo_addr[rd_ptr];
        sel_data = a_valid ? a_data : fifo_data[rd_ptr];
        sel_r15  = sel_req & (sel_addr == PC_REG);
        sel_wr   = sel_req & ~sel_r15;
    end

    // FIFO storage carries no reset; liveness is defined by rd_ptr/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Register-file write stage; wr_addr/wr_data hold on idle and R15 slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err_r15 <= 1'b0;
        end else begin
            wr_en <= sel_wr;
            if (sel_wr) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
            if (sel_r15) err_r15 <= 1'b1;
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        off      = '0;
        pending0 = wr_en && (wr_addr == rd_addr0);
        pending1 = wr_en && (wr_addr == rd_addr1);
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) begin
                if (fifo_addr[i] == rd_addr0) pending0 = 1'b1;
                if (fifo_addr[i] == rd_addr1) pending1 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_regfile_write_arbiter;

    localparam int W          = 32;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_valid;
    logic [3:0]   a_addr;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [3:0]   b_addr;
    logic [W-1:0] b_data;
    logic         stall_a;
    logic [3:0]   rd_addr0;
    logic [3:0]   rd_addr1;
    logic         pending0;
    logic         pending1;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         err_r15;

    regfile_write_arbiter #(.W(W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .stall_a(stall_a), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .pending0(pending0), .pending1(pending1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err_r15(err_r15)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [W-1:0] data;
    } ent_t;

    ent_t         q[$];
    int           head_wait;
    logic         m_wr_en;
    logic [3:0]   m_wr_addr;
    logic [W-1:0] m_wr_data;
    logic         m_err;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic m_pending(input logic [3:0] ra);
        logic hit;
        hit = m_wr_en && (m_wr_addr == ra);
        foreach (q[k]) if (q[k].addr == ra) hit = 1'b1;
        return hit;
    endfunction

    task automatic model_clear();
        q.delete();
        head_wait = 0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_err     = 1'b0;
    endtask

    // One clock: whoever owns the slot (A first, else oldest queued B) is written
    // unless it targets R15; B is queued only if room existed before the edge.
    task automatic model_edge();
        ent_t cur;
        bit   was_empty, was_full, took_head;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        took_head = 1'b0;
        cur.addr  = a_addr;
        cur.data  = a_data;
        if (!a_valid && !was_empty) begin
            cur = q.pop_front();
            took_head = 1'b1;
        end
        if (a_valid || took_head) begin
            if (cur.addr == 4'd15) begin
                m_wr_en = 1'b0;
                m_err   = 1'b1;
            end else begin
                m_wr_en   = 1'b1;
                m_wr_addr = cur.addr;
                m_wr_data = cur.data;
            end
        end else begin
            m_wr_en = 1'b0;
        end
        if (was_empty || took_head) head_wait = 0;
        else if (head_wait < STARVE_MAX) head_wait++;
        if (b_valid && !was_full) begin
            cur.addr = b_addr;
            cur.data = b_data;
            q.push_back(cur);
        end
    endtask

    task automatic drive_cycle(input logic av, input logic [3:0] aa, input logic [W-1:0] ad,
                               input logic bv, input logic [3:0] ba, input logic [W-1:0] bd,
                               input logic [3:0] r0, input logic [3:0] r1);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rd_addr0 = r0; rd_addr1 = r1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        rd_addr0 = 0; rd_addr1 = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
        n_checks++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: got %0b want 1", b_ready); end
        n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_stall_a: got %0b want 0", stall_a); end
        n_checks++; if (err_r15 !== 1'b0) begin n_fail++; $display("FAIL reset_err_r15: got %0b want 0", err_r15); end
        n_checks++; if ({pending0, pending1} !== 2'b00) begin n_fail++; $display("FAIL reset_pending: got %b want 00", {pending0, pending1}); end
        reset = 1'b0;
    endtask

    task automatic test_a_only();
        drive_cycle(1, 4'd3, 32'h11, 0, 0, 0, 4'd3, 4'd4);
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd3, 32'h11}) begin n_fail++; $display("FAIL a_only_write: got en=%0b addr=%0h data=%0h want 1/3/11", wr_en, wr_addr, wr_data); end
        n_checks++; if ({pending0, pending1} !== 2'b10) begin n_fail++; $display("FAIL a_only_pending: got %b want 10", {pending0, pending1}); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd3, 4'd4);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL a_only_idle_en: got %0b want 0", wr_en); end
        n_checks++; if ({wr_addr, wr_data} !== {4'd3, 32'h11}) begin n_fail++; $display("FAIL a_only_hold: got %0h/%0h want 3/11", wr_addr, wr_data); end
    endtask

    task automatic test_b_drain();
        drive_cycle(0, 0, 0, 1, 4'd5, 32'hAA, 4'd5, 4'd6);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b_drain_no_bypass: got %0b want 0", wr_en); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_drain_ready1: got %0b want 1", b_ready); end
        n_checks++; if ({pending0, pending1} !== 2'b10) begin n_fail++; $display("FAIL b_drain_pending: got %b want 10", {pending0, pending1}); end
        drive_cycle(0, 0, 0, 1, 4'd6, 32'hBB, 4'd5, 4'd6);
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd5, 32'hAA}) begin n_fail++; $display("FAIL b_drain_first: got en=%0b addr=%0h data=%0h want 1/5/AA", wr_en, wr_addr, wr_data); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_drain_ready2: got %0b want 1", b_ready); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd5, 4'd6);
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd6, 32'hBB}) begin n_fail++; $display("FAIL b_drain_second: got en=%0b addr=%0h data=%0h want 1/6/BB", wr_en, wr_addr, wr_data); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd5, 4'd6);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b_drain_done: got %0b want 0", wr_en); end
    endtask

    task automatic test_fill_starve();
        drive_cycle(1, 4'd1, 32'hA1, 1, 4'd8, 32'hC1, 4'd8, 4'd10);
        drive_cycle(1, 4'd1, 32'hA2, 1, 4'd9, 32'hC2, 4'd8, 4'd10);
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL starve_full: b_ready got %0b want 0", b_ready); end
        drive_cycle(1, 4'd1, 32'hA3, 1, 4'd10, 32'hC3, 4'd8, 4'd10);
        n_checks++; if (pending1 !== 1'b0) begin n_fail++; $display("FAIL starve_full_drop: pending1 got %0b want 0", pending1); end
        drive_cycle(1, 4'd1, 32'hA4, 0, 0, 0, 4'd8, 4'd10);
        n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL starve_early: stall_a got %0b want 0", stall_a); end
        drive_cycle(1, 4'd1, 32'hA5, 0, 0, 0, 4'd8, 4'd10);
        n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL starve_stall: stall_a got %0b want 1", stall_a); end
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd1, 32'hA5}) begin n_fail++; $display("FAIL starve_a_write: got en=%0b addr=%0h data=%0h want 1/1/A5", wr_en, wr_addr, wr_data); end
        // A ignores the stall once: it still wins and the stall persists
        drive_cycle(1, 4'd2, 32'hA6, 0, 0, 0, 4'd8, 4'd10);
        n_checks++; if ({stall_a, wr_addr, wr_data} !== {1'b1, 4'd2, 32'hA6}) begin n_fail++; $display("FAIL starve_violation: got stall=%0b addr=%0h data=%0h want 1/2/A6", stall_a, wr_addr, wr_data); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd8, 4'd10);
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd8, 32'hC1}) begin n_fail++; $display("FAIL starve_head_write: got en=%0b addr=%0h data=%0h want 1/8/C1", wr_en, wr_addr, wr_data); end
        n_checks++; if ({stall_a, b_ready} !== 2'b01) begin n_fail++; $display("FAIL starve_release: got stall/ready=%b want 01", {stall_a, b_ready}); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd8, 4'd10);
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd9, 32'hC2}) begin n_fail++; $display("FAIL starve_second: got en=%0b addr=%0h data=%0h want 1/9/C2", wr_en, wr_addr, wr_data); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd8, 4'd10);
        n_checks++; if ({wr_en, pending0} !== 2'b00) begin n_fail++; $display("FAIL starve_drained: got en/pend=%b want 00", {wr_en, pending0}); end
    endtask

    task automatic test_pending();
        drive_cycle(1, 4'd2, 32'h22, 1, 4'd7, 32'h77, 4'd7, 4'd8);
        n_checks++; if ({pending0, pending1} !== 2'b10) begin n_fail++; $display("FAIL pend_queued: got %b want 10", {pending0, pending1}); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd7, 4'd8);
        n_checks++; if ({wr_en, wr_addr, pending0, pending1} !== {1'b1, 4'd7, 2'b10}) begin n_fail++; $display("FAIL pend_on_port: got en=%0b addr=%0h pend=%b want 1/7/10", wr_en, wr_addr, {pending0, pending1}); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd7, 4'd8);
        n_checks++; if ({pending0, pending1} !== 2'b00) begin n_fail++; $display("FAIL pend_retired: got %b want 00", {pending0, pending1}); end
    endtask

    task automatic test_r15();
        drive_cycle(1, 4'd15, 32'hDEAD, 0, 0, 0, 0, 0);
        n_checks++; if ({wr_en, err_r15} !== 2'b01) begin n_fail++; $display("FAIL r15_a: got en/err=%b want 01", {wr_en, err_r15}); end
        drive_cycle(1, 4'd4, 32'h44, 0, 0, 0, 0, 0);
        n_checks++; if ({wr_en, wr_addr, err_r15} !== {1'b1, 4'd4, 1'b1}) begin n_fail++; $display("FAIL r15_sticky: got en=%0b addr=%0h err=%0b want 1/4/1", wr_en, wr_addr, err_r15); end
        drive_cycle(0, 0, 0, 1, 4'd15, 32'hBEEF, 4'd15, 0);
        n_checks++; if (pending0 !== 1'b1) begin n_fail++; $display("FAIL r15_b_queued: pending0 got %0b want 1", pending0); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd15, 0);
        n_checks++; if ({wr_en, wr_addr, wr_data, b_ready} !== {1'b0, 4'd4, 32'h44, 1'b1}) begin n_fail++; $display("FAIL r15_b_popped: got en=%0b addr=%0h data=%0h ready=%0b want 0/4/44/1", wr_en, wr_addr, wr_data, b_ready); end
        drive_cycle(0, 0, 0, 0, 0, 0, 4'd15, 0);
        n_checks++; if ({err_r15, pending0} !== 2'b10) begin n_fail++; $display("FAIL r15_after: got err/pend=%b want 10", {err_r15, pending0}); end
    endtask

    task automatic test_random();
        logic av, bv;
        logic [3:0] aa, ba;
        for (int i = 0; i < 400; i++) begin
            if (head_wait == STARVE_MAX) av = ($urandom_range(0, 9) == 0);
            else av = ($urandom_range(0, 2) != 0);
            bv = ($urandom_range(0, 1) == 1);
            aa = ($urandom_range(0, 39) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            ba = ($urandom_range(0, 39) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            drive_cycle(av, aa, $urandom, bv, ba, $urandom,
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            n_checks++; if (wr_en !== m_wr_en) begin n_fail++; $display("FAIL rand_wr_en cyc %0d: got %0b want %0b", i, wr_en, m_wr_en); end
            n_checks++; if (wr_addr !== m_wr_addr) begin n_fail++; $display("FAIL rand_wr_addr cyc %0d: got %0h want %0h", i, wr_addr, m_wr_addr); end
            n_checks++; if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL rand_wr_data cyc %0d: got %0h want %0h", i, wr_data, m_wr_data); end
            n_checks++; if (b_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_b_ready cyc %0d: got %0b want %0b", i, b_ready, q.size() < DEPTH); end
            n_checks++; if (stall_a !== (head_wait == STARVE_MAX)) begin n_fail++; $display("FAIL rand_stall_a cyc %0d: got %0b want %0b", i, stall_a, head_wait == STARVE_MAX); end
            n_checks++; if (err_r15 !== m_err) begin n_fail++; $display("FAIL rand_err_r15 cyc %0d: got %0b want %0b", i, err_r15, m_err); end
            n_checks++; if (pending0 !== m_pending(rd_addr0)) begin n_fail++; $display("FAIL rand_pending0 cyc %0d: got %0b want %0b", i, pending0, m_pending(rd_addr0)); end
            n_checks++; if (pending1 !== m_pending(rd_addr1)) begin n_fail++; $display("FAIL rand_pending1 cyc %0d: got %0b want %0b", i, pending1, m_pending(rd_addr1)); end
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 4'd2, 32'h22, 1, 4'd11, 32'hB1, 0, 0);
        drive_cycle(1, 4'd3, 32'h33, 1, 4'd12, 32'hB2, 0, 0);
        a_valid = 0; b_valid = 0; rd_addr0 = 4'd11; rd_addr1 = 4'd12;
        #1;
        n_checks++; if ({wr_en, b_ready, pending0, pending1} !== 4'b1011) begin n_fail++; $display("FAIL rmid_before: got en/ready/pend=%b want 1011", {wr_en, b_ready, pending0, pending1}); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 4'd0, 32'h0}) begin n_fail++; $display("FAIL rmid_async_wr: got en=%0b addr=%0h data=%0h want 0/0/0", wr_en, wr_addr, wr_data); end
        n_checks++; if ({b_ready, stall_a, pending0, pending1} !== 4'b1000) begin n_fail++; $display("FAIL rmid_async_ctl: got ready/stall/pend=%b want 1000", {b_ready, stall_a, pending0, pending1}); end
        #1 reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0, 0, 0, 0, 4'd11, 4'd12);
            n_checks++; if ({wr_en, pending0, pending1} !== 3'b000) begin n_fail++; $display("FAIL rmid_no_write cyc %0d: got en/pend=%b want 000", i, {wr_en, pending0, pending1}); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_a_only();
        test_b_drain();
        test_fill_starve();
        test_pending();
        test_r15();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
